cyber_player_gen: RTL and testbench
===================================

Name: cyber_player_gen

Overview:
Parametrised computer opponent for the Cyber War game. An internal maximal-length LFSR generates a pseudo-random value each cycle. That value is compared against a difficulty threshold, and the block emits registered single-cycle "press" pulses. Adds a minimum-gap cooldown, enable/clear control and an optional ramping-difficulty mode. Sits between the switch/difficulty inputs and the tug-of-war playfield logic, where press acts as the opponent's button.

Parameters:
W, 10, LFSR/threshold width; legal values 8, 10, 16 (elaboration error otherwise)
SEED, 1, LFSR reset value; SEED==0 is replaced by 1
COOLDOWN, 0, idle cycles forced after each press (0 = back-to-back allowed)
BOOST_STEP, 1, amount added to boost per press in ramp mode

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
en  input  1  run enable; when low, block freezes
clear  input  1  synchronous round restart (clears boost and cooldown)
mode  input  1  0 = fixed threshold, 1 = ramping difficulty
threshold  input  W  base difficulty; higher value = more presses
press  output  1  registered single-cycle opponent press
lfsr_q  output  W  current LFSR state (debug/observability)

Behaviour:
- Reset (async, active-high): lfsr = SEED (or 1 if SEED==0); press = 0; cooldown = 0; boost = 0.
- LFSR: Fibonacci, shift left, bit0 = XOR of tap bits. Taps: W=8 → {7,5,4,3}; W=10 → {9,6}; W=16 → {15,14,12,3}. Period 2^W−1; all-zero state never reached.
- LFSR advances each cycle en=1. It holds when en=0 and is unaffected by clear.
- Effective threshold eff:
  - mode=0: eff = threshold.
  - mode=1: eff = threshold + boost, saturating at 2^W−1. Sum uses a W+1-bit intermediate; no wrap-around.
- Raw decision: hit = (eff > lfsr_q). Strictly greater, unsigned.
- Cycle rule. With lfsr_q, cooldown and boost taken at edge k, press at edge k+1 is:
  - 0 if clear=1 (clear wins over everything);
  - else 0 if en=0;
  - else 1 iff hit and cooldown==0.
  - Latency is 1 cycle from lfsr_q to press.
- Cooldown, updated at the same edge:
  - clear → 0.
  - press issued → COOLDOWN.
  - en=1 and cooldown>0 → cooldown−1.
  - en=0 → hold.
- Boost:
  - clear → 0.
  - press issued and mode=1 → boost = min(boost+BOOST_STEP, 2^W−1).
  - Otherwise hold. boost is not cleared when mode drops to 0; it is only ignored.
- press is never high two consecutive cycles when COOLDOWN≥1.
- threshold==0 in mode 0 → press never asserts.
- Reset mid-cooldown: press drops to 0 immediately (asynchronously) and the counter clears. The first press is possible on the first edge after reset release.

Decomposition:
- Package cyber_pkg:
  - function lfsr_taps(W) returning the tap mask;
  - localparam list of legal widths;
  - typedef enum {MODE_FIXED, MODE_RAMP} for mode.
- Sub-module cyber_lfsr: parameters W and SEED; ports clk, reset, en, q. Instantiated once.
- Comparator, cooldown, boost and press register live in cyber_player_gen.

Test Plan:
1. W=10, SEED=1, mode=0, threshold=0, en=1 for 1023 cycles → press never 1. lfsr_q returns to 1 after exactly 1023 cycles and is never 0.
2. W=10, COOLDOWN=0, mode=0, threshold=1023, 1023 cycles → exactly 1022 presses; press is 0 only in the cycle after lfsr_q==1023.
3. COOLDOWN=3, threshold=1023 → presses spaced exactly 4 cycles apart, except where the cycle-2 gap (lfsr_q==1023) delays one.
4. mode=1, threshold=1000, BOOST_STEP=10 → boost steps 0,10,20,30 with presses; eff saturates at 1023 and never wraps to a small value. Assert clear → boost=0 and press=0 that edge.
5. en dropped for 20 cycles mid-run → lfsr_q, cooldown and boost frozen, press=0. Resume continues the exact sequence from the frozen state.
6. Assert reset between clock edges during cooldown=2 → press, cooldown and boost clear immediately and lfsr_q=SEED. After release, the sequence restarts identically to the start of scenario 2.

Source files
------------

// File: rtl/cyber_pkg.sv
// Shared definitions for the Cyber War computer opponent: legal LFSR widths,
// feedback tap masks and the difficulty-mode encoding.
package cyber_pkg;

  localparam int NUM_LEGAL_W = 3;
  localparam logic [NUM_LEGAL_W-1:0][4:0] LEGAL_W = {5'd16, 5'd10, 5'd8};

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RAMP  = 1'b1
  } mode_e;

  // Maximal-length Fibonacci tap masks, bit n set means stage n feeds the XOR.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      8:       return 16'h00B8;  // 7,5,4,3
      10:      return 16'h0240;  // 9,6
      16:      return 16'hD008;  // 15,14,12,3
      default: return 16'h0000;
    endcase
  endfunction

  function automatic bit is_legal_w(input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_LEGAL_W; i++)
      if (w == int'(LEGAL_W[i])) ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/cyber_lfsr.sv
// Fibonacci shift-left LFSR with hold enable. A zero seed is replaced by 1 so
// the register can never start in (or reach) the all-zero lock-up state.
module cyber_lfsr
  import cyber_pkg::*;
#(
  parameter int W    = 10,
  parameter int SEED = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] q
);

  if (!is_legal_w(W)) begin : g_bad_w
    $error("cyber_lfsr: W must be 8, 10 or 16");
  end

  localparam logic [15:0]  TAPS16   = lfsr_taps(W);
  localparam logic [W-1:0] TAPS     = TAPS16[W-1:0];
  localparam logic [W-1:0] SEED_W   = W'(SEED);
  localparam logic [W-1:0] SEED_EFF = (SEED_W == '0) ? W'(1) : SEED_W;

  logic [W-1:0] r_q;
  logic [W-1:0] w_q_nxt;

  assign w_q_nxt = {r_q[W-2:0], ^(r_q & TAPS)};

  // Advance once per enabled cycle, freeze otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   r_q <= SEED_EFF;
    else if (en) r_q <= w_q_nxt;
  end

  assign q = r_q;

endmodule

// File: rtl/cyber_player_gen.sv
// Computer opponent: compares the LFSR against a (possibly ramping) threshold
// and emits registered one-cycle press pulses, with a post-press cooldown.
module cyber_player_gen
  import cyber_pkg::*;
#(
  parameter int W          = 10,
  parameter int SEED       = 1,
  parameter int COOLDOWN   = 0,
  parameter int BOOST_STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clear,
  input  logic         mode,
  input  logic [W-1:0] threshold,
  output logic         press,
  output logic [W-1:0] lfsr_q
);

  localparam int           CD_W   = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
  localparam longint       MAXV   = (longint'(1) << W) - 1;
  // Step clamped to the boost range so the W+1-bit adder below cannot wrap.
  localparam logic [W:0]   STEP_W = (BOOST_STEP >= MAXV) ? {1'b0, {W{1'b1}}}
                                                          : (W+1)'(BOOST_STEP);

  logic            r_press;
  logic [CD_W-1:0] r_cd;
  logic [W-1:0]    r_boost;

  logic [W-1:0]    w_lfsr;
  logic [W:0]      w_sum;
  logic [W-1:0]    w_eff;
  logic            w_hit;
  logic            w_press_nxt;
  logic [W:0]      w_bsum;
  logic [W-1:0]    w_boost_inc;

  cyber_lfsr #(.W(W), .SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .q     (w_lfsr)
  );

  // Ramp mode adds the accumulated boost, saturating instead of wrapping.
  assign w_sum       = {1'b0, threshold} + {1'b0, r_boost};
  assign w_eff       = (mode == MODE_RAMP) ? (w_sum[W] ? {W{1'b1}} : w_sum[W-1:0])
                                           : threshold;
  assign w_hit       = (w_eff > w_lfsr);
  assign w_press_nxt = !clear && en && w_hit && (r_cd == '0);

  assign w_bsum      = {1'b0, r_boost} + STEP_W;
  assign w_boost_inc = w_bsum[W] ? {W{1'b1}} : w_bsum[W-1:0];

  // Press register: one cycle after the LFSR value it was decided on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_press <= 1'b0;
    else       r_press <= w_press_nxt;
  end

  // Cooldown counter: reload on press, count down only while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_cd <= '0;
    else if (clear)              r_cd <= '0;
    else if (w_press_nxt)        r_cd <= CD_LOAD;
    else if (en && r_cd != '0)   r_cd <= r_cd - 1'b1;
  end

  // Boost accumulates per ramp-mode press; kept (but unused) in fixed mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   r_boost <= '0;
    else if (clear)                              r_boost <= '0;
    else if (w_press_nxt && mode == MODE_RAMP)   r_boost <= w_boost_inc;
  end

  assign press  = r_press;
  assign lfsr_q = w_lfsr;

endmodule

// File: tb/tb_cyber_player_gen.sv
// Scoreboard bench: two W=10 opponents (COOLDOWN=0/STEP=1 and COOLDOWN=3/STEP=10)
// share stimulus; expected press/LFSR values are queued per edge and compared after it.
module tb_cyber_player_gen;

  logic       clk = 1'b0;
  logic       reset, en, clear, mode;
  logic [9:0] thr;
  logic       press0, press3;
  logic [9:0] lfsr0, lfsr3;

  always #5 clk = ~clk;

  cyber_player_gen #(.W(10), .SEED(1), .COOLDOWN(0), .BOOST_STEP(1)) dut0 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .mode(mode),
    .threshold(thr), .press(press0), .lfsr_q(lfsr0)
  );

  cyber_player_gen #(.W(10), .SEED(1), .COOLDOWN(3), .BOOST_STEP(10)) dut3 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .mode(mode),
    .threshold(thr), .press(press3), .lfsr_q(lfsr3)
  );

  typedef struct {
    bit         p0;
    bit         p3;
    logic [9:0] lfsr;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference state
  logic [9:0] m_lfsr = 10'd1;
  int m_cd0 = 0, m_b0 = 0, m_cd3 = 0, m_b3 = 0;
  int cyc = 0;

  function automatic logic [9:0] lfsr_next(input logic [9:0] q);
    return {q[8:0], q[9] ^ q[6]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp_v);
    end
  endtask

  // Reference behaviour of one opponent for the coming edge.
  task automatic model_edge(input int c, input int s, inout int cd, inout int boost,
                            output bit p);
    int eff;
    if (mode) eff = (int'(thr) + boost > 1023) ? 1023 : int'(thr) + boost;
    else      eff = int'(thr);
    if (clear) begin
      p = 0; cd = 0; boost = 0;
    end else if (!en) begin
      p = 0;
    end else begin
      p = (eff > int'(m_lfsr)) && (cd == 0);
      if (p) begin
        cd = c;
        if (mode) boost = (boost + s > 1023) ? 1023 : boost + s;
      end else if (cd > 0) begin
        cd = cd - 1;
      end
    end
  endtask

  task automatic step();
    exp_t e;
    bit p0, p3;
    model_edge(0, 1, m_cd0, m_b0, p0);
    model_edge(3, 10, m_cd3, m_b3, p3);
    if (en) m_lfsr = lfsr_next(m_lfsr);
    e.p0 = p0; e.p3 = p3; e.lfsr = m_lfsr;
    sbq.push_back(e);
    @(posedge clk); #1;
    cyc++;
    e = sbq.pop_front();
    chk("press0", 32'(press0), 32'(e.p0));
    chk("press3", 32'(press3), 32'(e.p3));
    chk("lfsr0",  32'(lfsr0),  32'(e.lfsr));
    chk("lfsr3",  32'(lfsr3),  32'(e.lfsr));
  endtask

  initial begin
    int first_ret, zero_seen, np0, np3, last3, min_gap, found;
    logic [9:0] frozen;

    reset = 1'b1; en = 1'b1; clear = 1'b0; mode = 1'b0; thr = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_press0", 32'(press0), 0);
    chk("rst_press3", 32'(press3), 0);
    chk("rst_lfsr0",  32'(lfsr0),  1);
    chk("rst_lfsr3",  32'(lfsr3),  1);
    reset = 1'b0;

    // 1: threshold 0 -> silent, full period
    first_ret = 0; zero_seen = 0; np0 = 0;
    for (int i = 1; i <= 1023; i++) begin
      step();
      if (lfsr0 == 10'd0) zero_seen = 1;
      if (lfsr0 == 10'd1 && first_ret == 0) first_ret = i;
      np0 += int'(press0) + int'(press3);
    end
    chk("s1_period",   32'(first_ret), 1023);
    chk("s1_nonzero",  32'(zero_seen), 0);
    chk("s1_presses",  32'(np0), 0);

    // 2/3: threshold max -> one gap per period; cooldown spacing on dut3
    thr = 10'd1023;
    np0 = 0; np3 = 0; last3 = -100; min_gap = 1000;
    for (int i = 1; i <= 1023; i++) begin
      step();
      np0 += int'(press0);
      if (press3) begin
        np3++;
        if (i - last3 < min_gap) min_gap = i - last3;
        last3 = i;
      end
    end
    chk("s2_press_count", 32'(np0), 1022);
    chk("s3_min_gap",     32'(min_gap), 4);
    chk("s3_some_press",  32'(np3 > 200), 1);

    // 4: ramp mode, saturation, boost retained across mode=0, then clear
    mode = 1'b1; thr = 10'd1000;
    repeat (300) step();
    mode = 1'b0; thr = 10'd0;
    repeat (30) step();
    mode = 1'b1; thr = 10'd0;          // eff is boost alone
    repeat (100) step();
    clear = 1'b1;
    step();
    chk("s4_clear_press0", 32'(press0), 0);
    chk("s4_clear_press3", 32'(press3), 0);
    clear = 1'b0;
    np0 = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      np0 += int'(press0) + int'(press3);
    end
    chk("s4_boost_cleared", 32'(np0), 0);

    // 5: freeze with en low
    mode = 1'b0; thr = 10'd700;
    repeat (10) step();
    en = 1'b0;
    frozen = lfsr0;
    np0 = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      np0 += int'(press0) + int'(press3);
    end
    chk("s5_frozen_lfsr", 32'(lfsr0), 32'(frozen));
    chk("s5_no_press",    32'(np0), 0);
    en = 1'b1;
    repeat (50) step();

    // 6: async reset during dut3 cooldown == 2
    thr = 10'd1023;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (press3) found = 1;
    end
    chk("s6_found_press", 32'(found), 1);
    step();                               // dut3 cooldown now 2
    #2;
    reset = 1'b1;
    #1;
    chk("s6_async_press0", 32'(press0), 0);
    chk("s6_async_press3", 32'(press3), 0);
    chk("s6_async_lfsr0",  32'(lfsr0), 1);
    chk("s6_async_lfsr3",  32'(lfsr3), 1);
    m_lfsr = 10'd1; m_cd0 = 0; m_b0 = 0; m_cd3 = 0; m_b3 = 0;
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("s6_first_press0", 32'(press0), 1);
    chk("s6_first_press3", 32'(press3), 1);
    repeat (40) step();
    mode = 1'b1; thr = 10'd0;             // boost must be zero after reset
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
